sd_sector_sched: RTL
====================

# sd_sector_sched

Sector-read scheduler sitting in front of the SD disk command manager. It shares the manager's 24-bit command port between two requesters with round-robin arbitration. For each granted request it issues the full command sequence: lazy INIT, BLOCK, OREAD, then READ/READBYTE per byte. It streams the resulting sector bytes back to the owner, and a per-command timeout converts a hung card into an error and forces re-initialisation.

## Interface
- SECTOR_BYTES, 512, bytes streamed per request (power of two, ≤1024)
- TIMEOUT, 65535, max cycles waited for any manager response (fits 16 bits)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  2  level request per requester; sampled only in IDLE
- req_block0 / req_block1  in  16  sector number, latched at grant
- grant  out  2  one-hot, one-cycle pulse when a request is accepted
- rd_data  out  8  sector byte
- rd_valid  out  1  one-cycle strobe per byte
- rd_owner  out  1  requester index owning the current transfer
- rd_last  out  1  high with the final byte's rd_valid
- done  out  2  one-hot pulse: transfer finished OK
- err  out  2  one-hot pulse: transfer aborted on timeout
- cmd_word  out  24  to manager: opcode [23:16], argument [15:0]
- cmd_start  out  1  to manager: one-cycle command strobe
- cmd_int  in  1  from manager: completion of INIT/OREAD/READ
- cmd_save  in  1  from manager: READBYTE result valid
- cmd_res  in  24  from manager: result, byte in [7:0]

## Operation
- Opcodes: INIT=1, BLOCK=2, OREAD=3, READ=5, READBYTE=7.
- FSM states: IDLE, INIT_ISS, INIT_WAIT, BLK_ISS, OPEN_ISS, OPEN_WAIT, RD_ISS, RD_WAIT, BYTE_ISS, BYTE_WAIT, FIN, FAIL.
- IDLE arbitration:
  - With any req bit set, grant the requester that did not win last.
  - After reset, priority favours requester 0.
  - Latch owner and block, pulse grant.
  - Next state is BLK_ISS if the `inited` flag is set, else INIT_ISS.
- INIT_ISS: cmd_word={1,0}, go INIT_WAIT. INIT_WAIT: on cmd_int set `inited`, go BLK_ISS.
- BLK_ISS: cmd_word={2,block}. No response expected; go OPEN_ISS next cycle.
- OPEN_ISS: cmd_word={3,0}, go OPEN_WAIT. OPEN_WAIT: on cmd_int clear byte counter, go RD_ISS.
- RD_ISS: cmd_word={5,0}, go RD_WAIT. RD_WAIT: on cmd_int go BYTE_ISS.
- BYTE_ISS: cmd_word={7,0}, go BYTE_WAIT.
- BYTE_WAIT: on cmd_save:
  - Drive rd_data=cmd_res[7:0] and pulse rd_valid.
  - If counter==SECTOR_BYTES-1: assert rd_last, go FIN. Else increment counter, go RD_ISS.
- FIN: pulse done[owner], go IDLE.
- Timeout:
  - In every *_WAIT state a 16-bit counter runs; it is cleared on entry to each wait.
  - Reaching TIMEOUT goes to FAIL.
  - FAIL: pulse err[owner], clear `inited`, go IDLE. Bytes already streamed are not retracted.
- cmd_start is high exactly in *_ISS states; cmd_word is valid that cycle and 0 otherwise.
- cmd_int/cmd_save are ignored outside the matching WAIT state. cmd_save in RD_WAIT and cmd_int in BYTE_WAIT are discarded.
- A req deassert after grant does not abort; the transfer runs to FIN/FAIL.
- Byte counter width is clog2(SECTOR_BYTES); it never wraps within a transfer.

## Timing
- All outputs are registered.
- Reset values: grant=0, rd_data=0, rd_valid=0, rd_owner=0, rd_last=0, done=0, err=0, cmd_word=0, cmd_start=0.
- Reset internals: state=IDLE, inited=0, last-winner=1.
- Reset mid-transfer returns to IDLE immediately with inited=0; no done/err pulse.
- Grant latency: req high in IDLE → grant pulse next edge.
- First cmd_start follows grant by 1 cycle.
- A response arriving the cycle after cmd_start is accepted.
- A response in the WAIT state produces the next cmd_start 1 cycle later.
- rd_valid: 1 cycle after cmd_save.
- done/err: 1 cycle after the last rd_valid or the timeout.
- Minimum per byte, with zero-latency manager: 4 cycles.
- Simultaneous req on both ports: one grant only; the loser is granted at the next IDLE if still requesting.

## Test plan
- Cold start, req=01, block0=0x0012, manager answers in 3 cycles:
  - Command order is INIT, {2,0x0012}, OREAD, then 512×(READ, READBYTE).
  - 512 rd_valid strobes with rd_owner=0.
  - rd_last on byte 511, then done=01.
- Second request from port 0 after success: no INIT issued; first cmd_word is 0x020000|block.
- req=11 held continuously: grants alternate 01,10,01; each transfer completes before the next grant.
- Manager never asserts cmd_int in OPEN_WAIT, TIMEOUT=100:
  - err[owner] pulses 100 cycles after entering OPEN_WAIT; no rd_valid.
  - The next request starts with INIT.
- Stray cmd_save in RD_WAIT and cmd_int in BYTE_WAIT: no extra rd_valid, byte count still exactly 512.
- rst asserted after byte 200: all outputs 0 at once; the following request issues INIT first.

Source files
------------

// File: rtl/sd_sector_sched.sv
// sd_sector_sched
// Sector-read scheduler in front of the SD disk command manager. Two
// requesters share the manager's 24-bit command port under round-robin
// arbitration. A granted request runs INIT (only when the card is not yet
// initialised), BLOCK, OREAD, then READ/READBYTE once per byte, and the bytes
// are streamed back to the owner. A wait that lasts TIMEOUT cycles aborts the
// transfer with err and forces re-initialisation on the next request.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   req_i[1:0]                     level request per requester
//   req_block0_i/req_block1_i      sector number, latched at grant
//   grant_o[1:0]                   one-hot grant pulse
//   rd_data_o/rd_valid_o           streamed byte and its strobe
//   rd_owner_o/rd_last_o           owner of the transfer, final-byte flag
//   done_o[1:0]/err_o[1:0]         one-hot completion / timeout pulses
//   cmd_word_o/cmd_start_o         command to the manager
//   cmd_int_i/cmd_save_i/cmd_res_i responses from the manager
//
// state     | meaning
// IDLE      | arbitrate; one extra cycle after a grant before issuing
// INIT_ISS  | issue INIT
// INIT_WAIT | wait for INIT completion (cmd_int)
// BLK_ISS   | issue BLOCK with the latched sector, no response expected
// OPEN_ISS  | issue OREAD
// OPEN_WAIT | wait for OREAD completion (cmd_int)
// RD_ISS    | issue READ
// RD_WAIT   | wait for READ completion (cmd_int)
// BYTE_ISS  | issue READBYTE
// BYTE_WAIT | wait for the byte (cmd_save)
// FIN       | pulse done to the owner
// FAIL      | pulse already sent on entry; drop the initialised flag
module sd_sector_sched #(
  parameter int SECTOR_BYTES = 512,
  parameter int TIMEOUT      = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [15:0] req_block0_i,
  input  logic [15:0] req_block1_i,
  output logic [1:0]  grant_o,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  output logic        rd_owner_o,
  output logic        rd_last_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic [23:0] cmd_word_o,
  output logic        cmd_start_o,
  input  logic        cmd_int_i,
  input  logic        cmd_save_i,
  input  logic [23:0] cmd_res_i
);

  localparam int CW = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SECTOR_BYTES - 1);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT_ISS  = 4'd1;
  localparam logic [3:0] S_INIT_WAIT = 4'd2;
  localparam logic [3:0] S_BLK_ISS   = 4'd3;
  localparam logic [3:0] S_OPEN_ISS  = 4'd4;
  localparam logic [3:0] S_OPEN_WAIT = 4'd5;
  localparam logic [3:0] S_RD_ISS    = 4'd6;
  localparam logic [3:0] S_RD_WAIT   = 4'd7;
  localparam logic [3:0] S_BYTE_ISS  = 4'd8;
  localparam logic [3:0] S_BYTE_WAIT = 4'd9;
  localparam logic [3:0] S_FIN       = 4'd10;
  localparam logic [3:0] S_FAIL      = 4'd11;

  localparam logic [7:0] OP_INIT  = 8'd1;
  localparam logic [7:0] OP_BLOCK = 8'd2;
  localparam logic [7:0] OP_OREAD = 8'd3;
  localparam logic [7:0] OP_READ  = 8'd5;
  localparam logic [7:0] OP_RBYTE = 8'd7;

  logic [3:0]    state_q, state_d;
  logic          inited_q, inited_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [15:0]   block_q, block_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   tmr_q, tmr_d;
  logic          pend_q, pend_d;
  logic [1:0]    grant_q, grant_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [23:0]   cmd_word_q, cmd_word_d;
  logic          cmd_start_q, cmd_start_d;
  logic          win, in_wait;
  logic [1:0]    owner_oh;

  // Only the low byte of a manager result carries sector data.
  logic unused_res;
  assign unused_res = ^cmd_res_i[23:8];

  always_comb begin
    state_d    = state_q;
    inited_d   = inited_q;
    last_d     = last_q;
    owner_d    = owner_q;
    block_d    = block_q;
    cnt_d      = cnt_q;
    pend_d     = 1'b0;
    grant_d    = 2'b00;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    done_d     = 2'b00;
    err_d      = 2'b00;
    owner_oh   = owner_q ? 2'b10 : 2'b01;
    win        = (req_i == 2'b11) ? ~last_q : req_i[1];
    in_wait    = state_q inside {S_INIT_WAIT, S_OPEN_WAIT, S_RD_WAIT, S_BYTE_WAIT};

    case (state_q)
      S_IDLE: begin
        // pend_q holds off issuing for one cycle so cmd_start trails grant.
        if (pend_q) begin
          state_d = inited_q ? S_BLK_ISS : S_INIT_ISS;
        end else if (|req_i) begin
          grant_d = win ? 2'b10 : 2'b01;
          owner_d = win;
          last_d  = win;
          block_d = win ? req_block1_i : req_block0_i;
          pend_d  = 1'b1;
        end
      end
      S_INIT_ISS:  state_d = S_INIT_WAIT;
      S_INIT_WAIT: if (cmd_int_i) begin
        inited_d = 1'b1;
        state_d  = S_BLK_ISS;
      end
      S_BLK_ISS:   state_d = S_OPEN_ISS;
      S_OPEN_ISS:  state_d = S_OPEN_WAIT;
      S_OPEN_WAIT: if (cmd_int_i) begin
        cnt_d   = '0;
        state_d = S_RD_ISS;
      end
      S_RD_ISS:    state_d = S_RD_WAIT;
      S_RD_WAIT:   if (cmd_int_i) state_d = S_BYTE_ISS;
      S_BYTE_ISS:  state_d = S_BYTE_WAIT;
      S_BYTE_WAIT: if (cmd_save_i) begin
        rd_data_d  = cmd_res_i[7:0];
        rd_valid_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          rd_last_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_RD_ISS;
        end
      end
      S_FIN: begin
        done_d  = owner_oh;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        inited_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A response on the last allowed cycle still wins over the timeout.
    if (in_wait && (state_d == state_q) && (tmr_q == TMO_LAST)) begin
      state_d = S_FAIL;
      err_d   = owner_oh;
    end

    tmr_d = (in_wait && (state_d == state_q)) ? tmr_q + 16'd1 : 16'd0;

    // Command outputs follow the next state so they line up with *_ISS.
    cmd_start_d = 1'b1;
    cmd_word_d  = 24'd0;
    case (state_d)
      S_INIT_ISS: cmd_word_d = {OP_INIT, 16'd0};
      S_BLK_ISS:  cmd_word_d = {OP_BLOCK, block_q};
      S_OPEN_ISS: cmd_word_d = {OP_OREAD, 16'd0};
      S_RD_ISS:   cmd_word_d = {OP_READ, 16'd0};
      S_BYTE_ISS: cmd_word_d = {OP_RBYTE, 16'd0};
      default:    cmd_start_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      inited_q    <= 1'b0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      block_q     <= 16'd0;
      cnt_q       <= '0;
      tmr_q       <= 16'd0;
      pend_q      <= 1'b0;
      grant_q     <= 2'b00;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      cmd_word_q  <= 24'd0;
      cmd_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inited_q    <= inited_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      block_q     <= block_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      pend_q      <= pend_d;
      grant_q     <= grant_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_word_q  <= cmd_word_d;
      cmd_start_q <= cmd_start_d;
    end
  end

  assign grant_o     = grant_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_owner_o  = owner_q;
  assign rd_last_o   = rd_last_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cmd_word_o  = cmd_word_q;
  assign cmd_start_o = cmd_start_q;

endmodule
